serial_subtractor_8bit: RTL and testbench
=========================================

# serial_subtractor_8bit

Bit-serial, multi-cycle subtractor that computes `a - b - borrow_in` one bit per clock. It is the inverse-operation counterpart to the ripple-carry adder datapath. It sits between pixel/feature accumulators and the comparison logic of the digit recognizer. It trades throughput for area and exposes valid/ready handshakes on both sides.

## Interface
- `WIDTH`, default 8: operand and result width in bits (≥2).
- `clk`, input, 1: sole clock; all state updates on rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: operands on `a`/`b`/`borrow_in` are valid.
- `in_ready`, output, 1: block can accept operands (high only in IDLE).
- `a`, input, WIDTH: minuend, unsigned.
- `b`, input, WIDTH: subtrahend, unsigned.
- `borrow_in`, input, 1: initial borrow.
- `out_valid`, output, 1: `diff`/`underflow` hold a finished result.
- `out_ready`, input, 1: consumer accepts the result.
- `diff`, output, WIDTH: `(a - b - borrow_in) mod 2^WIDTH`.
- `underflow`, output, 1: final borrow out, i.e. 1 iff `a < b + borrow_in` (unsigned).
- `signed_ovf`, output, 1: present only with `SUB_SIGNED_OVF_EN` (see Configuration).

## Operation
- FSM states are IDLE, SHIFT and DONE.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid & in_ready`: latch `a`, `b`, `borrow_in` into internal shift registers; clear bit counter; go to SHIFT.
  - Inputs need not be held after the accepting edge.
- **SHIFT**
  - Each cycle: bit `i` (LSB first) computes `d_i = a_i ^ b_i ^ br` and `br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)`.
  - `d_i` shifts into the result register from the MSB side; the borrow register updates to `br'`.
  - The counter increments each cycle.
  - After the cycle processing bit WIDTH-1: go to DONE, load `underflow` with the final borrow.
  - `in_valid` is ignored in this state.
- **DONE**
  - `out_valid=1`; `diff`/`underflow` stable.
  - On `out_ready`: go to IDLE, drop `out_valid`.
  - `diff`/`underflow` keep their last value until the next result completes.
- Arithmetic wraps modulo 2^WIDTH.
  - Example: `0x00 - 0x01` gives `diff=0xFF`, `underflow=1`.
- Reset mid-operation (any state): the next edge forces IDLE and discards the partial result.

## Timing
- Reset values after a `rst` edge:
  - State IDLE, `in_ready=1`, `out_valid=0`.
  - `diff=0`, `underflow=0`, `signed_ovf=0`.
  - Counter and borrow register = 0.
- Acceptance edge E0. Bit i is processed on edge E(i+1). `out_valid` rises after edge E(WIDTH), i.e. latency is WIDTH cycles from acceptance (8 for default).
- `in_ready` falls the cycle after acceptance and stays low through SHIFT and DONE.
- The earliest next acceptance is the cycle after the `out_ready` handshake edge. Minimum initiation interval is WIDTH+2 cycles with `out_ready` held high.
- `out_ready` asserted before DONE has no effect.
- Back-pressure: DONE holds indefinitely while `out_ready=0`.
- `in_ready`/`out_valid` are decoded from registered state only; there are no combinational input-to-output paths.

## Configuration
- `SUB_SIGNED_OVF_EN` defined:
  - Adds output `signed_ovf`.
  - It is registered at the DONE transition as `a[W-1] ^ b[W-1]` AND `a[W-1] ^ diff[W-1]` (two's-complement overflow).
  - Its reset value is 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `subtractor_pkg`:
  - `sub_state_t` enum (IDLE, SHIFT, DONE).
  - `SUB_DEFAULT_WIDTH = 8`.
- Sub-module `full_subtractor`: 1-bit combinational cell with inputs `a`, `b`, `borrow_in` and outputs `diff`, `borrow_out`, instantiated once in the serial datapath.
- The counter width is `$clog2(WIDTH)`.

## Test plan
- Reset then idle: `rst` for 2 cycles → `in_ready=1`, `out_valid=0`, `diff=0x00`, `underflow=0`.
- Basic subtraction: `a=0x5A`, `b=0x23`, `borrow_in=0`, `out_ready=1` → `out_valid` 8 cycles after acceptance, `diff=0x37`, `underflow=0`.
- Wrap-around: `a=0x00`, `b=0x01`, `borrow_in=0` → `diff=0xFF`, `underflow=1`; and `a=0x10`, `b=0x10`, `borrow_in=1` → `diff=0xFF`, `underflow=1`.
- Back-pressure: result of `0x80 - 0x01` held with `out_ready=0` for 5 cycles → `diff=0x7F` stable, `in_ready=0`, a new `in_valid` is ignored. `out_ready=1` → IDLE the next cycle.
- Reset mid-SHIFT: assert `rst` 3 cycles after acceptance of `0xFF - 0x0F` → IDLE next cycle, `out_valid` never rises, then `0x09 - 0x04` completes with `diff=0x05`.
- With `SUB_SIGNED_OVF_EN`: `0x80 - 0x01` → `signed_ovf=1`; `0x05 - 0x03` → `signed_ovf=0`.

Source files
------------

// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   sub_state_t       : controller states (IDLE, SHIFT, DONE)
//   SUB_DEFAULT_WIDTH : default operand/result width
package subtractor_pkg;

    localparam int SUB_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: diff = a - b - borrow_in.
// Ports:
//   a, b, borrow_in : operand bits and incoming borrow
//   diff            : difference bit
//   borrow_out      : borrow into the next more significant bit
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor computing a - b - borrow_in, LSB first, one bit per
// clock, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b, borrow_in     : unsigned minuend, subtrahend, initial borrow
//   out_valid, out_ready: result handshake (out_valid high only in DONE)
//   diff, underflow     : result mod 2^WIDTH and final borrow out
//   signed_ovf          : two's-complement overflow, only when the macro
//                         SUB_SIGNED_OVF_EN is defined
module serial_subtractor_8bit
    import subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             underflow
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             signed_ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sub_state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Only the upper WIDTH-1 result bits need storing; the newest bit comes
    // straight from the cell, so res_next is the complete shifted value.
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             br;
    logic             cell_d;
    logic             cell_bo;
    logic             last_bit;
    logic             accept;

    full_subtractor u_cell (
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .borrow_in (br),
        .diff      (cell_d),
        .borrow_out(cell_bo)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE);
    assign last_bit  = (cnt == LAST_BIT);
    assign res_next  = {cell_d, res_sr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Control and visible result registers: cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            br        <= 1'b0;
            diff      <= '0;
            underflow <= 1'b0;
        end else if (accept) begin
            cnt <= '0;
            br  <= borrow_in;
        end else if (state == SHIFT) begin
            cnt <= cnt + 1'b1;
            br  <= cell_bo;
            if (last_bit) begin
                diff      <= res_next;
                underflow <= cell_bo;
            end
        end
    end

    // Operand/result shift registers: contents are don't-care outside SHIFT,
    // so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sr <= a;
            b_sr <= b;
        end else if (state == SHIFT) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= res_next[WIDTH-1:1];
        end
    end

`ifdef SUB_SIGNED_OVF_EN
    // Operand sign bits are shifted out of a_sr/b_sr, so keep copies.
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk) begin
        if (accept) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end
    end

    // On the last bit cell_d is the sign bit of the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            signed_ovf <= 1'b0;
        end else if (state == SHIFT && last_bit) begin
            signed_ovf <= (a_msb ^ b_msb) & (a_msb ^ cell_d);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Self-checking bench for serial_subtractor_8bit (WIDTH = 8). Compile with
// SUB_SIGNED_OVF_EN defined to also cover the signed overflow output.
module tb_serial_subtractor_8bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       borrow_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] diff;
    logic       underflow;
`ifdef SUB_SIGNED_OVF_EN
    logic       signed_ovf;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_subtractor_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .borrow_in (borrow_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .underflow (underflow)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .signed_ovf(signed_ovf)
`endif
    );

    // Reference model: plain integer arithmetic on the operand values.
    function automatic logic [7:0] model_diff(input logic [7:0] x, input logic [7:0] y, input logic bi);
        int r;
        r = int'(x) - int'(y) - int'(bi);
        return r[7:0];
    endfunction

    function automatic logic model_uf(input logic [7:0] x, input logic [7:0] y, input logic bi);
        return int'(x) < (int'(y) + int'(bi));
    endfunction

    function automatic logic model_ovf(input logic [7:0] x, input logic [7:0] y, input logic bi);
        int sx, sy, r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = sx - sy - int'(bi);
        return (r < -128) || (r > 127);
    endfunction

    // Stimulus helper (no checking): starts at a negedge with out_ready high,
    // performs one full transaction and returns at the negedge after the
    // output handshake.
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_bi,
                          output logic [7:0] d, output logic u, output logic o,
                          output int lat, output logic rdy_seen, output logic timed_out);
        int w;
        w = 0;
        out_ready = 1'b1;
        while (!in_ready && w < 50) begin
            @(posedge clk); @(negedge clk); w++;
        end
        a = op_a; b = op_b; borrow_in = op_bi; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); borrow_in = 1'($urandom);
        lat = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            rdy_seen |= in_ready;
            @(posedge clk); lat++; @(negedge clk);
        end
        timed_out = !out_valid;
        d = diff;
        u = underflow;
`ifdef SUB_SIGNED_OVF_EN
        o = signed_ovf;
`else
        o = 1'b0;
`endif
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff got=%h want=00", diff); end
        n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow got=%b want=0", underflow); end
`ifdef SUB_SIGNED_OVF_EN
        n_cmp++; if (signed_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_signed_ovf got=%b want=0", signed_ovf); end
`endif
    endtask

    task automatic test_directed;
        logic [16:0] vec [6];
        logic [7:0] d, va, vb;
        logic u, o, rs, to, vbi;
        int lat;
        vec = '{{8'h5A, 8'h23, 1'b0}, {8'h00, 8'h01, 1'b0}, {8'h10, 8'h10, 1'b1},
                {8'h80, 8'h01, 1'b0}, {8'h05, 8'h03, 1'b0}, {8'h7F, 8'h80, 1'b1}};
        for (int i = 0; i < 6; i++) begin
            {va, vb, vbi} = vec[i];
            run_op(va, vb, vbi, d, u, o, lat, rs, to);
            n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL dir_timeout[%0d] got=%b want=0", i, to); end
            n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL dir_latency[%0d] got=%0d want=8", i, lat); end
            n_cmp++; if (rs !== 1'b0) begin n_fail++; $display("FAIL dir_in_ready_busy[%0d] got=%b want=0", i, rs); end
            n_cmp++; if (d !== model_diff(va, vb, vbi)) begin n_fail++; $display("FAIL dir_diff[%0d] got=%h want=%h", i, d, model_diff(va, vb, vbi)); end
            n_cmp++; if (u !== model_uf(va, vb, vbi)) begin n_fail++; $display("FAIL dir_underflow[%0d] got=%b want=%b", i, u, model_uf(va, vb, vbi)); end
`ifdef SUB_SIGNED_OVF_EN
            n_cmp++; if (o !== model_ovf(va, vb, vbi)) begin n_fail++; $display("FAIL dir_signed_ovf[%0d] got=%b want=%b", i, o, model_ovf(va, vb, vbi)); end
`endif
        end
    endtask

    task automatic test_random;
        logic [7:0] d, va, vb;
        logic u, o, rs, to, vbi;
        int lat;
        for (int i = 0; i < 40; i++) begin
            va = 8'($urandom); vb = 8'($urandom); vbi = 1'($urandom);
            run_op(va, vb, vbi, d, u, o, lat, rs, to);
            n_cmp++; if (to !== 1'b0 || lat != 8) begin n_fail++; $display("FAIL rnd_latency[%0d] got=%0d timeout=%b want=8", i, lat, to); end
            n_cmp++; if (d !== model_diff(va, vb, vbi)) begin n_fail++; $display("FAIL rnd_diff[%0d] %h-%h-%b got=%h want=%h", i, va, vb, vbi, d, model_diff(va, vb, vbi)); end
            n_cmp++; if (u !== model_uf(va, vb, vbi)) begin n_fail++; $display("FAIL rnd_underflow[%0d] %h-%h-%b got=%b want=%b", i, va, vb, vbi, u, model_uf(va, vb, vbi)); end
`ifdef SUB_SIGNED_OVF_EN
            n_cmp++; if (o !== model_ovf(va, vb, vbi)) begin n_fail++; $display("FAIL rnd_signed_ovf[%0d] got=%b want=%b", i, o, model_ovf(va, vb, vbi)); end
`endif
        end
    endtask

    task automatic test_back_pressure;
        int w;
        out_ready = 1'b0;
        a = 8'h80; b = 8'h01; borrow_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 40) begin
            @(posedge clk); @(negedge clk); w++;
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_done_timeout got=%b want=1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            a = 8'h00; b = 8'h01; borrow_in = 1'b0; in_valid = 1'b1;
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d] got=%b want=1", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, in_ready); end
            n_cmp++; if (diff !== 8'h7F || underflow !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d] got=%h/%b want=7f/0", i, diff, underflow); end
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (diff !== 8'h7F) begin n_fail++; $display("FAIL bp_diff_kept got=%h want=7f", diff); end
    endtask

    task automatic test_reset_mid_shift;
        logic [7:0] d;
        logic u, o, rs, to, seen;
        int lat;
        out_ready = 1'b1;
        a = 8'hFF; b = 8'h0F; borrow_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (diff !== 8'h00 || underflow !== 1'b0) begin n_fail++; $display("FAIL rmid_cleared got=%h/%b want=00/0", diff, underflow); end
        seen = 1'b0;
        repeat (12) begin seen |= out_valid; @(posedge clk); @(negedge clk); end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_no_result got=%b want=0", seen); end
        run_op(8'h09, 8'h04, 1'b0, d, u, o, lat, rs, to);
        n_cmp++; if (to !== 1'b0 || d !== 8'h05 || u !== 1'b0) begin n_fail++; $display("FAIL rmid_next_op got=%h/%b timeout=%b want=05/0", d, u, to); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        logic u, o, rs, to;
        int lat;
        run_op(8'h33, 8'h44, 1'b1, d, u, o, lat, rs, to);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_handshake got=%b want=1", in_ready); end
        n_cmp++; if (d !== 8'hEE || u !== 1'b1) begin n_fail++; $display("FAIL b2b_first got=%h/%b want=ee/1", d, u); end
        run_op(8'hC8, 8'h64, 1'b1, d, u, o, lat, rs, to);
        n_cmp++; if (to !== 1'b0 || lat != 8 || d !== 8'h63 || u !== 1'b0) begin n_fail++; $display("FAIL b2b_second got=%h/%b lat=%0d want=63/0 lat=8", d, u, lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_pressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
